// File: rtl/uart_pkg.sv
// Shared UART constants: default bit period and receiver state encoding.
// Pure definitions, no logic; no latency or backpressure.
package uart_pkg;

  // 50 MHz core clock, 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    PARITY    = ST_PARITY,
    STOP      = ST_STOP,
    WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line; 2-cycle latency, resets to idle-high.
// No backpressure: samples every cycle.
module rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, optional parity, one stop bit; load pulses the cycle after the stop sample.
// No backpressure: each frame is presented once on RX_data and the consumer must capture it on load.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [8:0] RX_data,
  output logic       load,
  output logic       busy
);

  localparam logic [15:0] FULL_LIM = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LIM = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic        ODD      = 1'(PARITY_ODD);

  rx_state_t   state, state_nxt;
  logic        rx_s;
  logic        tick;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        parity_err;
  logic        framing_err;

  rx_sync u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s)
  );

  assign busy        = (state != IDLE);
  assign framing_err = ~rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // tick marks a sample point; START samples mid start bit, later states a full bit apart
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      IDLE: if (!rx_s) state_nxt = START;
      START: if (timer == HALF_LIM) begin
        tick      = 1'b1;
        state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: if (timer == FULL_LIM) begin
        tick = 1'b1;
        if (bit_idx == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (timer == FULL_LIM) begin
        tick      = 1'b1;
        state_nxt = STOP;
      end
      STOP: if (timer == FULL_LIM) begin
        tick      = 1'b1;
        state_nxt = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_err <= 1'b0;
      RX_data    <= 9'h000;
      load       <= 1'b0;
    end else begin
      load <= 1'b0;
      if (tick || state == IDLE || state == WAIT_HIGH) timer <= '0;
      else                                             timer <= timer + 16'd1;

      case (state)
        IDLE: if (!rx_s) begin
          parity_err <= 1'b0;
          bit_idx    <= '0;
        end
        DATA: if (tick) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        PARITY: if (tick) parity_err <= ((^shreg) ^ rx_s) != ODD;
        STOP: if (tick) begin
          RX_data <= {parity_err | framing_err, shreg};
          load    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit, even parity.
// Expected frames are queued as they are sent and matched against each load pulse.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [8:0] RX_data;
  logic       load;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         load_cnt = 0;
  int         base;
  logic       prev_load = 1'b0;
  logic [8:0] sb[$];
  logic [8:0] exp_frame;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .PARITY_EN    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .RX_data (RX_data),
    .load    (load),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every load must match the oldest queued frame and be a single-cycle pulse
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt++;
      chk("load_single_cycle", {31'd0, prev_load}, 32'd0);
      chk("load_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        exp_frame = sb.pop_front();
        chk("rx_data", {23'd0, RX_data}, {23'd0, exp_frame});
      end
    end
    prev_load = load;
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    sb.push_back({pflip | ~stop, d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ pflip);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 * CPB && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rx_data", {23'd0, RX_data}, 32'd0);
    chk("reset_load", {31'd0, load}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // good frame, even parity
    base = load_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    drain("a5_drain");
    chk("a5_loads", load_cnt - base, 32'd1);

    // parity error
    base = load_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_bit(1'b1);
    drain("3c_drain");
    chk("3c_loads", load_cnt - base, 32'd1);

    // framing error followed by a long break
    base = load_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      repeat (CPB) @(negedge clk);
      if (k % 10 == 9) chk("break_busy", {31'd0, busy}, 32'd1);
    end
    drain("55_drain");
    chk("break_loads", load_cnt - base, 32'd1);
    rx = 1'b1;
    for (int i = 0; i < 8 && busy; i++) @(negedge clk);
    chk("break_release_idle", {31'd0, busy}, 32'd0);
    repeat (2 * CPB) @(negedge clk);
    chk("break_no_repeat", load_cnt - base, 32'd1);

    // short glitch on idle line
    base = load_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 12 && busy; i++) @(negedge clk);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_load", load_cnt - base, 32'd0);

    // back-to-back frames
    base = load_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_bit(1'b1);
    drain("b2b_drain");
    chk("b2b_loads", load_cnt - base, 32'd2);

    // reset in the middle of data bit 4 (7E bits 0..3 = 0,1,1,1; bit 4 = 1)
    base = load_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_load", {31'd0, load}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_rx_data", {23'd0, RX_data}, 32'd0);
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("aborted_no_load", load_cnt - base, 32'd0);
    send_frame(8'h7E, 1'b0, 1'b1);
    send_bit(1'b1);
    drain("7e_drain");
    chk("7e_loads", load_cnt - base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
